// File: rtl/bcd_down_timer.sv
// Loadable multi-digit BCD countdown timer with run/pause/done control.
// Counts down to zero and stops there; never wraps to all nines.
module bcd_dec_cell (
  input  logic [3:0] digit_i,
  input  logic       borrow_i,
  output logic [3:0] digit_o,
  output logic       borrow_o
);
  always_comb begin
    digit_o  = digit_i;
    borrow_o = 1'b0;
    if (borrow_i) begin
      if (digit_i == 4'd0) begin
        digit_o  = 4'd9;
        borrow_o = 1'b1;
      end else begin
        digit_o = digit_i - 4'd1;
      end
    end
  end
endmodule

module bcd_down_timer #(
  parameter int DIGITS = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic                  start,
  input  logic                  pause,
  input  logic                  dec,
  output logic [4*DIGITS-1:0]   Count,
  output logic                  count_eq_0,
  output logic                  running,
  output logic                  done,
  output logic                  expired
);
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [4*DIGITS-1:0] count_q, count_d;
  logic                expired_q, expired_d;
  logic [4*DIGITS-1:0] dec_val;
  logic [4*DIGITS-1:0] clamp_val;
  logic [DIGITS:0]     borrow;

  assign borrow[0] = 1'b1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_cell
    bcd_dec_cell u_cell (
      .digit_i  (count_q[4*g +: 4]),
      .borrow_i (borrow[g]),
      .digit_o  (dec_val[4*g +: 4]),
      .borrow_o (borrow[g+1])
    );
  end

  always_comb begin
    clamp_val = load_val;
    for (int i = 0; i < DIGITS; i++) begin
      if (load_val[4*i +: 4] > 4'd9) clamp_val[4*i +: 4] = 4'd9;
    end
  end

  // A borrow out of the top digit means every digit was zero.
  assign count_eq_0 = borrow[DIGITS];
  assign Count      = count_q;
  assign running    = (state_q == RUN);
  assign done       = (state_q == DONE);
  assign expired    = expired_q;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    expired_d = 1'b0;
    if (load) begin
      count_d = clamp_val;
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!pause && start) begin
            if (count_eq_0) begin
              state_d   = DONE;
              expired_d = 1'b1;
            end else begin
              state_d = RUN;
            end
          end
        end
        RUN: begin
          if (pause) begin
            state_d = PAUSE;
          end else if (dec && !count_eq_0) begin
            count_d = dec_val;
            if (dec_val == '0) begin
              state_d   = DONE;
              expired_d = 1'b1;
            end
          end
        end
        PAUSE: begin
          if (!pause && start) state_d = RUN;
        end
        DONE: begin
          state_d = DONE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      count_q   <= '0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      expired_q <= expired_d;
    end
  end
endmodule

// File: doc/bcd_down_timer.md
# bcd_down_timer

Loadable multi-digit BCD countdown timer: the decrementing counterpart of the team's mod-10 up-counter. Each digit counts 9..0 and borrows from the next digit up, and the whole count stops at zero rather than wrapping. A small run/pause/done state machine gates the decrements. `dec` is driven by the one-cycle tick from the clock divider, and `Count` feeds the BCD-to-seven-segment decoders directly.

## Interface
- `DIGITS`, default 2: number of BCD digits; count width is 4*DIGITS.
- `clock`, in, 1: system clock; all state changes on the rising edge.
- `reset`, in, 1: asynchronous, active-low. Low forces the reset state immediately.
- `load`, in, 1: load `load_val` into `Count` and return to IDLE.
- `load_val`, in, 4*DIGITS: BCD preset, least significant digit in bits [3:0].
- `start`, in, 1: begin or resume counting.
- `pause`, in, 1: suspend counting.
- `dec`, in, 1: decrement request (divider tick), honoured only in RUN.
- `Count`, out, 4*DIGITS: current BCD value, registered.
- `count_eq_0`, out, 1: combinational decode, 1 when `Count` is all zeros.
- `running`, out, 1: 1 in RUN.
- `done`, out, 1: 1 in DONE.
- `expired`, out, 1: one-cycle pulse on entry to DONE.

## Operation
- **States:** IDLE, RUN, PAUSE, DONE (2-bit encoded register).
- **Reset state:** IDLE; `Count` = 0; `running`, `done` and `expired` = 0; `count_eq_0` = 1.
- **Per-cycle input priority:** `load` > `pause` > `start` > `dec`.
- **`load`, any state:**
  - `Count` <= `load_val`; next state IDLE.
  - Any `load_val` digit > 9 is clamped to 9.
  - No `expired` pulse is generated.
- **IDLE:**
  - `start` with `Count` != 0 -> RUN.
  - `start` with `Count` == 0 -> DONE.
  - `dec` is ignored.
- **RUN:**
  - `pause` -> PAUSE.
  - `dec` decrements `Count` by one in BCD.
  - If `Count` == 0 after the update -> DONE.
- **PAUSE:**
  - `start` -> RUN.
  - `dec` is ignored; `Count` is held.
- **DONE:**
  - Holds until `load`; `start`, `pause` and `dec` are ignored.
- **Digit decrement rule:**
  - Digit 0 always receives borrow-in = 1 when a decrement occurs.
  - Each digit: if borrow-in and digit == 0 -> 9 with borrow-out = 1; if borrow-in and digit != 0 -> digit-1 with borrow-out = 0; no borrow-in -> hold.
  - Implemented as a per-digit chain of DIGITS identical decrement cells.
- **No wrap-around:** a decrement is never applied while `Count` == 0, so 00 never becomes 99.
- **Outputs:** `running`, `done` and `count_eq_0` are pure state/`Count` decodes. `expired` is registered.

## Timing
- **Latency:** every input sampled at edge N takes effect in `Count`/state after edge N. One cycle of latency; there is no handshake.
- **Terminal decrement:** the decrement from 0…01 to 0 and the RUN->DONE transition happen on the same edge. `count_eq_0`, `done` and `expired` all rise after that edge. `expired` falls one cycle later.
- **Start at zero:** IDLE->DONE via `start` with zero count also produces exactly one `expired` pulse.
- **Tick collisions:**
  - `dec` coinciding with `pause`: the tick is dropped.
  - `dec` coinciding with `start` in IDLE/PAUSE: the tick is dropped, because the state is not yet RUN.
- **Back-to-back `dec`:** consecutive `dec` cycles decrement once per cycle. There is no minimum spacing.
- **Reset mid-run:** `reset` low asynchronously clears to the reset state, including mid-decrement and mid-`expired` pulse. Release is synchronous to `clock` via the standard release flop upstream.
- **Load in DONE:** `done` drops the cycle after `load`.

## Test plan
- **Reset:** assert `reset`=0 mid-RUN with `Count`=37 -> `Count`=00, IDLE, `count_eq_0`=1, `expired`=0 immediately, without waiting for an edge.
- **Borrow:** load 20, start, 1 `dec` -> 19. Then 9 more `dec` -> 10, 1 more -> 09. Checks borrow across the digit boundary.
- **Terminal:** load 02, start, 2 `dec` -> `Count`=00, `done`=1, a single-cycle `expired`. Further `dec` keeps 00, with no wrap to 99.
- **Pause/resume:**
  - Load 15, start, `dec`, pause, 5 `dec` -> `Count` holds at 14.
  - Then start, `dec` -> 13.
  - `pause`+`dec` in the same cycle -> no change.
- **Load priority and clamp:**
  - `load` with `load_val`=8'hA7 during RUN with simultaneous `dec` -> `Count`=97, state IDLE, no `expired`.
  - Start at zero (load 00, start) -> DONE, one `expired` pulse.
- **Random soak, DIGITS=3:**
  - Random `dec`/`pause`/`start` traffic; compare against a binary reference model converted to BCD.
  - Check `count_eq_0` == (`Count`==0) every cycle.
